// File: rtl/comparator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comparator_pkg : relation codes and sequencer states for the         |
// |                  comparator self-test block                          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package comparator_pkg;

    localparam logic [2:0] REL_GT = 3'b100;
    localparam logic [2:0] REL_EQ = 3'b010;
    localparam logic [2:0] REL_LT = 3'b001;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t APPLY = 2'd1;
    localparam state_t CHECK = 2'd2;
    localparam state_t DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/comparator_bist_ref.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comparator_bist_ref : golden unsigned magnitude relation code        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module comparator_bist_ref
    import comparator_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       expected
);

    always_comb begin
        expected = REL_LT;
        if (a > b) begin
            expected = REL_GT;
        end else if (a == b) begin
            expected = REL_EQ;
        end
    end

endmodule
`default_nettype wire

// File: rtl/comparator_bist.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comparator_bist : exhaustive operand sweep and check of an attached  |
// |                   magnitude comparator                               |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module comparator_bist
    import comparator_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [2:0]       c_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_c
);

    localparam int VW = 2 * WIDTH;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    state_t           r_state;
    logic [VW-1:0]    r_vec;
    logic [SW-1:0]    r_settle;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic [2:0]       r_fail_c;

    logic [2:0]       w_expected;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    comparator_bist_ref #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a        (r_vec[VW-1:WIDTH]),
        .b        (r_vec[WIDTH-1:0]),
        .expected (w_expected)
    );

    assign w_mismatch = (c_in != w_expected);
    // Counter sticks at all-ones once saturated; the sweep itself carries on
    assign w_err_next = (w_mismatch && !(&r_err)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_vec    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fail_a <= '0;
            r_fail_b <= '0;
            r_fail_c <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= APPLY;
                        r_vec    <= '0;
                        r_settle <= SETTLE_LOAD;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_err    <= '0;
                        r_fail_a <= '0;
                        r_fail_b <= '0;
                        r_fail_c <= '0;
                    end
                end
                APPLY: begin
                    if (r_settle == '0) begin
                        r_state <= CHECK;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && (r_err == '0)) begin
                        r_fail_a <= r_vec[VW-1:WIDTH];
                        r_fail_b <= r_vec[WIDTH-1:0];
                        r_fail_c <= c_in;
                    end
                    if (&r_vec) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_state  <= APPLY;
                        r_vec    <= r_vec + 1'b1;
                        r_settle <= SETTLE_LOAD;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a_out     = r_vec[VW-1:WIDTH];
    assign b_out     = r_vec[WIDTH-1:0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;
    assign fail_c    = r_fail_c;

endmodule
`default_nettype wire

// File: tb/tb_comparator_bist.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_comparator_bist : sweeps two self-test instances against table-   |
// |                      driven comparator responses                     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_comparator_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance 1: WIDTH=1, SETTLE=1, ERR_W=8
    logic       rst1, start1;
    logic       a1, b1, busy1, done1, pass1, fa1, fb1;
    logic [2:0] c1, fc1;
    logic [7:0] err1;
    logic [2:0] tab1 [4];

    // Instance 2: WIDTH=2, SETTLE=2, ERR_W=2
    logic       rst2, start2;
    logic [1:0] a2, b2, fa2, fb2, err2;
    logic       busy2, done2, pass2;
    logic [2:0] c2, fc2;
    logic [2:0] tab2 [16];

    // Attached comparator behaviour is a per-vector response table
    assign c1 = tab1[{a1, b1}];
    assign c2 = tab2[{a2, b2}];

    comparator_bist #(.WIDTH(1), .SETTLE(1), .ERR_W(8)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a_out(a1), .b_out(b1),
        .c_in(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_a(fa1), .fail_b(fb1), .fail_c(fc1)
    );

    comparator_bist #(.WIDTH(2), .SETTLE(2), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst2), .start(start2), .a_out(a2), .b_out(b2),
        .c_in(c2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_a(fa2), .fail_b(fb2), .fail_c(fc2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] golden(input int a, input int b);
        if (a > b)  return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    // Sweep instance 1; optionally re-pulse start at a given busy cycle
    task automatic sweep1(input string name, input int restart_at);
        int cnt = 0, first = -1, k = 0, trace_bad = 0, err_exp;
        logic [1:0] fv;
        for (int v = 0; v < 4; v++) begin
            if (tab1[v] != golden(v >> 1, v & 1)) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
        err_exp = (cnt > 255) ? 255 : cnt;
        fv = (first < 0) ? 2'b00 : 2'(first);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        while (busy1 && k < 40) begin
            if ({a1, b1} != 2'(k / 2)) trace_bad++;
            start1 = (k == restart_at);
            @(negedge clk);
            k++;
        end
        start1 = 1'b0;
        check_eq({name, "_busy_cycles"}, k, 8);
        check_eq({name, "_trace"}, trace_bad, 0);
        check_eq({name, "_done"}, done1, 1);
        check_eq({name, "_err_count"}, err1, err_exp);
        check_eq({name, "_pass"}, pass1, (cnt == 0));
        check_eq({name, "_fail_vec"}, {fa1, fb1, fc1},
                 (first < 0) ? 0 : {fv, tab1[first]});
        repeat (3) @(negedge clk);
        check_eq({name, "_hold"}, {done1, busy1, a1, b1}, 4'b1011);
    endtask

    task automatic sweep2(input string name);
        int cnt = 0, first = -1, k = 0, trace_bad = 0, err_exp;
        logic [3:0] fv;
        for (int v = 0; v < 16; v++) begin
            if (tab2[v] != golden(v >> 2, v & 3)) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
        err_exp = (cnt > 3) ? 3 : cnt;
        fv = (first < 0) ? 4'h0 : 4'(first);
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        while (busy2 && k < 200) begin
            if ({a2, b2} != 4'(k / 3)) trace_bad++;
            @(negedge clk);
            k++;
        end
        check_eq({name, "_busy_cycles"}, k, 48);
        check_eq({name, "_trace"}, trace_bad, 0);
        check_eq({name, "_done"}, done2, 1);
        check_eq({name, "_err_count"}, err2, err_exp);
        check_eq({name, "_pass"}, pass2, (cnt == 0));
        check_eq({name, "_fail_vec"}, {fa2, fb2, fc2},
                 (first < 0) ? 0 : {fv, tab2[first]});
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
        for (int v = 0; v < 4; v++)  tab1[v] = golden(v >> 1, v & 1);
        for (int v = 0; v < 16; v++) tab2[v] = golden(v >> 2, v & 3);
        repeat (2) @(negedge clk);
        check_eq("reset1", {a1, b1, busy1, done1, pass1, err1, fa1, fb1, fc1}, 0);
        check_eq("reset2", {a2, b2, busy2, done2, pass2, err2, fa2, fb2, fc2}, 0);
        rst1 = 1'b0; rst2 = 1'b0;
        @(negedge clk);

        sweep1("good", -1);

        for (int v = 0; v < 4; v++) tab1[v] = 3'b010;
        sweep1("stuck_eq", -1);

        for (int v = 0; v < 4; v++) tab1[v] = 3'b000;
        sweep1("stuck_zero", -1);

        // Mid-sweep reset during vector (1,0)
        for (int v = 0; v < 4; v++) tab1[v] = golden(v >> 1, v & 1);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_vec", {busy1, a1, b1}, 3'b110);
        #2 rst1 = 1'b1;
        #1 check_eq("async_rst", {a1, b1, busy1, done1, pass1, err1, fa1, fb1, fc1}, 0);
        @(negedge clk); rst1 = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post_rst_idle", {busy1, done1}, 0);
        sweep1("post_rst", -1);

        for (int v = 0; v < 4; v++) tab1[v] = (v == 3) ? 3'b011 : golden(v >> 1, v & 1);
        sweep1("restart_ignored", 2);

        for (int i = 0; i < 4; i++) begin
            for (int v = 0; v < 4; v++)
                tab1[v] = ($urandom_range(0, 1) != 0) ? golden(v >> 1, v & 1)
                                                      : 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sweep1($sformatf("rand1_%0d", i), -1);
        end

        for (int v = 0; v < 16; v++) tab2[v] = ~golden(v >> 2, v & 3);
        sweep2("inverted");

        for (int v = 0; v < 16; v++) tab2[v] = golden(v >> 2, v & 3);
        sweep2("good2");

        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < 16; v++)
                tab2[v] = ($urandom_range(0, 3) != 0) ? golden(v >> 2, v & 3)
                                                      : 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sweep2($sformatf("rand2_%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/comparator_bist.md
Name: comparator_bist

Overview:
- Hardware self-test sequencer for the team's magnitude comparator. It is the driving and checking end of the comparator interface: it sweeps every {a,b} operand pair into a comparator instance, samples the 3-bit relation code the comparator returns, and checks it against a golden model.
- Reports pass/fail, an error count and the first failing vector.
- Sits beside a comparator instance in built-in self-test or bring-up builds.

Parameters:
- WIDTH, 1, operand width in bits for a and b.
- SETTLE, 1, clock cycles each vector is held before c_in is sampled (minimum 1).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- a_out  output  WIDTH  operand a driven to the comparator.
- b_out  output  WIDTH  operand b driven to the comparator.
- c_in  input  3  comparator relation code: [2]=a>b, [1]=a==b, [0]=a<b.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; results valid.
- pass  output  1  done and zero errors.
- err_count  output  ERR_W  number of mismatching vectors, saturating.
- fail_a  output  WIDTH  a of first failing vector.
- fail_b  output  WIDTH  b of first failing vector.
- fail_c  output  3  c_in captured at first failing vector.

Behaviour:
- Reset (async, rst=1): state IDLE. a_out, b_out, busy, done, pass, err_count, fail_a, fail_b, fail_c are all 0. Internal vector counter vec and settle counter are 0.
- vec is 2*WIDTH bits wide: a_out=vec[2W-1:W], b_out=vec[W-1:0]. Both outputs are registered and only change on a vector advance.
- Golden expected code:
  - 3'b100 if a>b, 3'b010 if a==b, 3'b001 if a<b (unsigned).
  - Any c_in other than the expected value is a mismatch, including non-one-hot codes such as 000 or 011.
- IDLE:
  - On start, go to APPLY.
  - Clear vec, err_count and the fail_* registers; set busy=1, done=0, pass=0; load settle counter with SETTLE-1.
- APPLY:
  - Hold vec. Decrement the settle counter each cycle.
  - When it reads 0, go to CHECK.
  - The vector is held for exactly SETTLE cycles before CHECK.
- CHECK (one cycle):
  - Sample c_in and compare to expected(vec).
  - On mismatch: err_count+1, saturating at all-ones. If this is the first mismatch (err_count was 0), latch fail_a, fail_b and fail_c from this cycle.
  - If vec is all-ones, go to DONE. Otherwise vec+1, reload the settle counter, go to APPLY.
- Each vector costs SETTLE+1 cycles; a full sweep is 2^(2W)*(SETTLE+1) cycles.
- DONE:
  - busy=0, done=1. pass = (err_count==0), using the final count including the last CHECK.
  - Results hold until the next start, which behaves as from IDLE (clears results, restarts).
  - a_out and b_out keep the last vector.
- start while busy is ignored; no restart and no effect.
- rst asserted mid-sweep aborts immediately to the reset values. No partial results are retained.
- The vec wrap from all-ones is never taken; the terminal vector ends the sweep.
- Error counter saturation does not stop the sweep. fail_* always reflect the first mismatch only.

Decomposition:
- Shared package comparator_pkg:
  - localparams for relation codes: REL_GT=3'b100, REL_EQ=3'b010, REL_LT=3'b001.
  - State enum IDLE/APPLY/CHECK/DONE.
- Sub-module comparator_bist_ref: combinational golden model, a,b (WIDTH) -> expected 3-bit code, instantiated once.
- Sequencer, counters and result registers live in comparator_bist.

Test Plan:
1. WIDTH=1, SETTLE=1, correct comparator attached; start pulse -> busy for 8 cycles; a_out/b_out step 00,01,10,11, two cycles each; then done=1, pass=1, err_count=0.
2. WIDTH=1, comparator c stuck at 3'b010 -> done after 8 cycles; err_count=2; pass=0; fail_a=0, fail_b=1, fail_c=3'b010.
3. WIDTH=1, c_in forced 3'b000 -> err_count=4, fail_a=0, fail_b=0, fail_c=3'b000.
4. WIDTH=1 correct DUT; rst pulsed during the vector (1,0) -> all outputs 0 asynchronously; a new start runs a clean sweep with pass=1.
5. start reasserted at the 3rd busy cycle -> ignored; sweep still completes at cycle 8 with the same result.
6. WIDTH=2, SETTLE=2, ERR_W=2, c_in inverted (~expected) -> 16 vectors, 48 cycles; err_count saturates at 3; fail_a=0, fail_b=0, fail_c=3'b101.
